ssd_mux_driver: RTL and testbench
=================================

# ssd_mux_driver

Time-multiplexed driver for a bank of N common-anode seven-segment digits, generalising the single-digit code-to-segment decoder to a scanned multi-digit display. Per-digit 4-bit codes and decimal points are loaded with a strobe, double-buffered so that every frame comes from a single load, and scanned one digit at a time under a programmable refresh divider with anti-ghosting dead time. Optional leading-zero blanking is included. The block sits between the calculator datapath (BCD result plus sign) and the board's segment and anode pins.

## Interface
- N_DIGITS, 4, number of digits scanned; legal range 1..8
- REFRESH_DIV, 100000, clock cycles per digit slot; must be ≥ DEAD_CYCLES+1 and ≥ 2
- DEAD_CYCLES, 2, cycles at the start of each slot with all anodes off; legal range 0..REFRESH_DIV-1

- ssd_mux_driver_port_clk  in  1  single clock; all state on rising edge
- ssd_mux_driver_port_rst_n  in  1  reset, asynchronous, active-low
- ssd_mux_driver_port_inp  in  4*N_DIGITS  packed digit codes; bits [4i+3:4i] = digit i; digit 0 = least significant, rightmost
- ssd_mux_driver_port_dp  in  N_DIGITS  decimal point per digit, 1 = lit
- ssd_mux_driver_port_load  in  1  capture strobe for inp, dp and lzb_en
- ssd_mux_driver_port_lzb_en  in  1  leading-zero blanking enable, captured with load
- ssd_mux_driver_port_cc  out  7  segments {a,b,c,d,e,f,g}, active-low
- ssd_mux_driver_port_dp_out  out  1  decimal point, active-low
- ssd_mux_driver_port_an  out  N_DIGITS  anode enables, active-low, at most one low at a time
- ssd_mux_driver_port_frame_done  out  1  one-cycle pulse at each frame boundary

## Operation
- Code map, bits {a..g}, 0 = segment lit:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - A=1111111 (blank), B=1100000, C=0110001, D=1000010, E=0111010 (plus sign), F=1011010 (minus sign)
- Buffering uses a pending register {codes, dp, lzb_en, valid} and an active register {codes, dp, lzb_en}.
  - Load writes the pending register and sets valid. A later load in the same frame overwrites it; the last load wins.
- Frame boundary is idx = N_DIGITS-1 and cnt = REFRESH_DIV-1.
  - At the boundary, if valid is set, active takes pending and valid is cleared.
  - If load is asserted in the boundary cycle, the inp, dp and lzb_en values in that cycle go directly to active and valid is cleared.
- Scan counters:
  - cnt counts 0..REFRESH_DIV-1; at terminal count it wraps to 0 and idx increments.
  - idx counts 0..N_DIGITS-1 and wraps to 0.
  - Frame period is N_DIGITS × REFRESH_DIV cycles.
- Leading-zero blanking applies when active lzb_en = 1.
  - Code 0 at digit i (i ≥ 1) displays as blank when every digit j > i holds 0 or A.
  - Digit 0 is never blanked.
  - Signs and glyphs B–F stop the blanking.
- Decimal point: dp_out = ~active dp[idx] during the lit part of a slot. Digits blanked by leading-zero blanking keep their dp.
- Slot phases:
  - cnt < DEAD_CYCLES: an = all 1, cc = 1111111, dp_out = 1.
  - Otherwise: an has a single 0 at bit idx, and cc and dp_out show digit idx.

## Timing
- All outputs are registered. Outputs in cycle t+1 reflect the {idx, cnt, active} state in cycle t.
- frame_done is high for exactly one cycle, the cycle after the boundary cycle, aligned with the first output cycle of slot 0.
- Load-to-display latency is at most one frame plus one cycle, and no frame mixes data from two loads.
- Reset (rst_n low) acts immediately, asynchronously:
  - cnt = 0, idx = 0, pending.valid = 0.
  - active codes = all A, dp = 0, lzb_en = 0.
  - Outputs: an = all 1, cc = 1111111, dp_out = 1, frame_done = 0.
- Reset during a frame abandons the frame. After release, scanning restarts at slot 0 and the display stays blank until the first load reaches active.
- When DEAD_CYCLES = 0 there is no off period. When N_DIGITS = 1, every slot is a frame boundary and frame_done pulses every REFRESH_DIV cycles.

## Test plan
Parameters for all scenarios: N_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2.

- Basic scan: load inp=0x1234, dp=0000, lzb_en=0.
  - From the first frame after the next boundary, each slot is 2 cycles of an=1111/cc=1111111, then 6 cycles of:
    - slot 0: an=1110, cc=1001100
    - slot 1: an=1101, cc=0000110
    - slot 2: an=1011, cc=0010010
    - slot 3: an=0111, cc=1001111
  - frame_done pulses once every 32 cycles.
- Leading-zero blanking: load inp=0x0070 with lzb_en=1.
  - Digits 3 and 2 show 1111111, digit 1 shows 0001111, digit 0 shows 0000001.
  - Reload with lzb_en=0: digit 3 shows 0000001.
  - Load inp=0xF007 with lzb_en=1: digits 2 and 1 show 0000001 and digit 3 shows 1011010.
- No tearing: load 0x1111 and then 0x2222 within the same frame.
  - The next frame shows 0x2222 on all four digits; 0x1111 never appears.
- Load in the boundary cycle: assert load=1 with inp=0x9999 exactly at idx=3, cnt=7.
  - Slot 0 of the very next frame shows cc=0000100.
- Reset mid-frame: pull rst_n low at idx=2, cnt=5.
  - In the same cycle, an=1111, cc=1111111, dp_out=1, frame_done=0.
  - After release, everything stays blank until a load, and the first frame_done comes 32 cycles after release.
- Decimal point: load dp=0100 with inp=0x5555.
  - dp_out=0 only in the lit cycles of slot 2; dp_out=1 elsewhere, including dead cycles.

Source files
------------

// File: rtl/ssd_mux_driver.sv
// ssd_mux_driver
//   Time-multiplexed driver for N common-anode seven-segment digits.
//   Digit codes, decimal points and the leading-zero-blanking enable are
//   captured into a pending buffer on load and moved to the active buffer
//   only at a frame boundary, so each frame shows data from a single load.
//   Each digit slot lasts REFRESH_DIV cycles; the first DEAD_CYCLES of a slot
//   keep all anodes off to stop ghosting between digits.
//
// Ports
//   ssd_mux_driver_port_clk        clock, rising edge
//   ssd_mux_driver_port_rst_n      asynchronous active-low reset
//   ssd_mux_driver_port_inp        packed 4-bit codes, digit 0 in bits [3:0]
//   ssd_mux_driver_port_dp         decimal point per digit, 1 = lit
//   ssd_mux_driver_port_load       capture strobe for inp / dp / lzb_en
//   ssd_mux_driver_port_lzb_en     leading-zero blanking enable
//   ssd_mux_driver_port_cc         segments {a..g}, active-low
//   ssd_mux_driver_port_dp_out     decimal point, active-low
//   ssd_mux_driver_port_an         anode enables, active-low, one-cold
//   ssd_mux_driver_port_frame_done one-cycle pulse after each frame boundary
module ssd_mux_driver #(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DEAD_CYCLES = 2
) (
    input  logic                    ssd_mux_driver_port_clk,
    input  logic                    ssd_mux_driver_port_rst_n,
    input  logic [4*N_DIGITS-1:0]   ssd_mux_driver_port_inp,
    input  logic [N_DIGITS-1:0]     ssd_mux_driver_port_dp,
    input  logic                    ssd_mux_driver_port_load,
    input  logic                    ssd_mux_driver_port_lzb_en,
    output logic [6:0]              ssd_mux_driver_port_cc,
    output logic                    ssd_mux_driver_port_dp_out,
    output logic [N_DIGITS-1:0]     ssd_mux_driver_port_an,
    output logic                    ssd_mux_driver_port_frame_done
);

    localparam int unsigned CODES_W = 4 * N_DIGITS;
    localparam int unsigned CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST    = IDX_W'(N_DIGITS - 1);
    localparam logic [6:0]         SEG_BLANK   = 7'b1111111;
    localparam logic [3:0]         CODE_ZERO   = 4'h0;
    localparam logic [3:0]         CODE_BLANK  = 4'hA;
    localparam logic [CODES_W-1:0] CODES_RESET = {N_DIGITS{CODE_BLANK}};

    // Code-to-segment map, bits {a..g}, 0 = segment lit
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0111010;
            4'hF:    seg = 7'b1011010;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Scan counters
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    // Pending and active buffers
    logic [CODES_W-1:0]  pend_codes_q, pend_codes_d;
    logic [N_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                pend_lzb_q, pend_lzb_d;
    logic                pend_valid_q, pend_valid_d;
    logic [CODES_W-1:0]  act_codes_q, act_codes_d;
    logic [N_DIGITS-1:0] act_dp_q, act_dp_d;
    logic                act_lzb_q, act_lzb_d;

    // Registered outputs
    logic [6:0]          cc_q, cc_d;
    logic                dp_out_q, dp_out_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic                frame_done_q, frame_done_d;

    logic                boundary_c;
    logic                dead_c;
    logic [N_DIGITS-1:0] lzb_blank_c;
    logic                higher_ok_c;
    logic [3:0]          scan_code_c;
    logic [3:0]          sel_code_c;
    logic                sel_dp_c;
    logic                sel_blank_c;

    assign boundary_c = (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);

    // Anti-ghosting window at the start of every slot
    if (DEAD_CYCLES == 0) begin : g_no_dead
        assign dead_c = 1'b0;
    end else begin : g_dead
        assign dead_c = (cnt_q < CNT_W'(DEAD_CYCLES));
    end

    // Counters and double buffer
    always_comb begin
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        pend_codes_d = pend_codes_q;
        pend_dp_d    = pend_dp_q;
        pend_lzb_d   = pend_lzb_q;
        pend_valid_d = pend_valid_q;
        act_codes_d  = act_codes_q;
        act_dp_d     = act_dp_q;
        act_lzb_d    = act_lzb_q;

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        if (boundary_c) begin
            // A load in the boundary cycle bypasses pending and wins
            if (ssd_mux_driver_port_load) begin
                act_codes_d = ssd_mux_driver_port_inp;
                act_dp_d    = ssd_mux_driver_port_dp;
                act_lzb_d   = ssd_mux_driver_port_lzb_en;
            end else if (pend_valid_q) begin
                act_codes_d = pend_codes_q;
                act_dp_d    = pend_dp_q;
                act_lzb_d   = pend_lzb_q;
            end
            pend_valid_d = 1'b0;
        end else if (ssd_mux_driver_port_load) begin
            pend_codes_d = ssd_mux_driver_port_inp;
            pend_dp_d    = ssd_mux_driver_port_dp;
            pend_lzb_d   = ssd_mux_driver_port_lzb_en;
            pend_valid_d = 1'b1;
        end
    end

    // Leading-zero blanking: walk down from the most significant digit while
    // everything above is still zero or blank
    always_comb begin
        lzb_blank_c = '0;
        higher_ok_c = 1'b1;
        scan_code_c = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            scan_code_c    = act_codes_q[4*i +: 4];
            lzb_blank_c[i] = act_lzb_q && (i != 0) && (scan_code_c == CODE_ZERO) && higher_ok_c;
            higher_ok_c    = higher_ok_c &&
                             ((scan_code_c == CODE_ZERO) || (scan_code_c == CODE_BLANK));
        end
    end

    // Digit select and output formation
    always_comb begin
        sel_code_c   = CODE_BLANK;
        sel_dp_c     = 1'b0;
        sel_blank_c  = 1'b0;
        an_d         = '1;
        cc_d         = SEG_BLANK;
        dp_out_d     = 1'b1;
        frame_done_d = boundary_c;

        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_code_c  = act_codes_q[4*i +: 4];
                sel_dp_c    = act_dp_q[i];
                sel_blank_c = lzb_blank_c[i];
                if (!dead_c) begin
                    an_d[i] = 1'b0;
                end
            end
        end

        if (!dead_c) begin
            cc_d     = sel_blank_c ? SEG_BLANK : seg_decode(sel_code_c);
            dp_out_d = ~sel_dp_c;
        end
    end

    // State register
    always_ff @(posedge ssd_mux_driver_port_clk or negedge ssd_mux_driver_port_rst_n) begin
        if (!ssd_mux_driver_port_rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_codes_q <= CODES_RESET;
            pend_dp_q    <= '0;
            pend_lzb_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            act_codes_q  <= CODES_RESET;
            act_dp_q     <= '0;
            act_lzb_q    <= 1'b0;
            cc_q         <= SEG_BLANK;
            dp_out_q     <= 1'b1;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_codes_q <= pend_codes_d;
            pend_dp_q    <= pend_dp_d;
            pend_lzb_q   <= pend_lzb_d;
            pend_valid_q <= pend_valid_d;
            act_codes_q  <= act_codes_d;
            act_dp_q     <= act_dp_d;
            act_lzb_q    <= act_lzb_d;
            cc_q         <= cc_d;
            dp_out_q     <= dp_out_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ssd_mux_driver_port_cc         = cc_q;
    assign ssd_mux_driver_port_dp_out     = dp_out_q;
    assign ssd_mux_driver_port_an         = an_q;
    assign ssd_mux_driver_port_frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_mux_driver.sv
// Testbench for ssd_mux_driver (N_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2).
// Stimulus pushes the hand-computed frame it expects to see next; a monitor
// pops one entry per frame_done and checks the following 32 output cycles.
module tb_ssd_mux_driver;

    localparam int unsigned N  = 4;
    localparam int unsigned RD = 8;
    localparam int unsigned DC = 2;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] SF = 7'b1011010;
    localparam logic [6:0] SB = 7'b1111111;

    typedef struct packed {
        logic [3:0][6:0] cc;
        logic [3:0]      dp;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] inp;
    logic [3:0]  dp;
    logic        load;
    logic        lzb_en;
    logic [6:0]  cc;
    logic        dp_out;
    logic [3:0]  an;
    logic        fd;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    ssd_mux_driver #(
        .N_DIGITS   (N),
        .REFRESH_DIV(RD),
        .DEAD_CYCLES(DC)
    ) dut (
        .ssd_mux_driver_port_clk       (clk),
        .ssd_mux_driver_port_rst_n     (rst_n),
        .ssd_mux_driver_port_inp       (inp),
        .ssd_mux_driver_port_dp        (dp),
        .ssd_mux_driver_port_load      (load),
        .ssd_mux_driver_port_lzb_en    (lzb_en),
        .ssd_mux_driver_port_cc        (cc),
        .ssd_mux_driver_port_dp_out    (dp_out),
        .ssd_mux_driver_port_an        (an),
        .ssd_mux_driver_port_frame_done(fd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [6:0] c3, input logic [6:0] c2,
                                input logic [6:0] c1, input logic [6:0] c0,
                                input logic [3:0] d);
        exp_t e;
        e.cc[3] = c3;
        e.cc[2] = c2;
        e.cc[1] = c1;
        e.cc[0] = c0;
        e.dp    = d;
        return e;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic z);
        inp    = v;
        dp     = d;
        lzb_en = z;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fd !== 1'b1 && n < 100);
        check("frame_seen", 32'(fd), 32'd1);
    endtask

    // Mid-frame load; displayed from the next frame boundary
    task automatic frame_test(input logic [15:0] v, input logic [3:0] d, input logic z,
                              input exp_t e);
        idle(5);
        exp_q.push_back(e);
        do_load(v, d, z);
        wait_frame();
        wait_frame();
    endtask

    // Monitor: output cycle c after frame_done reflects scan cycle c-1
    initial begin
        exp_t       e;
        logic [3:0] an_exp;
        logic [12:0] want;
        int         s;
        int         p;
        forever begin
            @(negedge clk);
            while (rst_n === 1'b1 && fd === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int c = 1; c <= 32; c++) begin
                    @(negedge clk);
                    s = (c - 1) / 8;
                    p = (c - 1) % 8;
                    if (p < int'(DC)) begin
                        want = {1'b0, 4'b1111, 1'b1, SB};
                    end else begin
                        an_exp    = 4'b1111;
                        an_exp[s] = 1'b0;
                        want      = {1'b0, an_exp, ~e.dp[s], e.cc[s]};
                    end
                    if (c == 32) want[12] = 1'b1;
                    check($sformatf("scan_slot%0d_ph%0d", s, p),
                          {19'b0, fd, an, dp_out, cc}, {19'b0, want});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n  = 1'b1;
        load   = 1'b0;
        lzb_en = 1'b0;
        inp    = '0;
        dp     = '0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_outputs", {19'b0, fd, an, dp_out, cc}, {19'b0, 1'b0, 4'b1111, 1'b1, SB});
        idle(2);
        rst_n = 1'b1;
        wait_frame();

        // Basic scan
        frame_test(16'h1234, 4'b0000, 1'b0, mk(S1, S2, S3, S4, 4'b0000));
        // Leading-zero blanking on / off / stopped by a sign
        frame_test(16'h0070, 4'b0000, 1'b1, mk(SB, SB, S7, S0, 4'b0000));
        frame_test(16'h0070, 4'b0000, 1'b0, mk(S0, S0, S7, S0, 4'b0000));
        frame_test(16'hF007, 4'b0000, 1'b1, mk(SF, S0, S0, S7, 4'b0000));

        // Two loads in one frame: only the last is ever shown
        idle(5);
        exp_q.push_back(mk(S2, S2, S2, S2, 4'b0000));
        do_load(16'h1111, 4'b0000, 1'b0);
        idle(4);
        do_load(16'h2222, 4'b0000, 1'b0);
        wait_frame();
        wait_frame();

        // Load exactly in the boundary cycle (idx=3, cnt=7)
        idle(31);
        exp_q.push_back(mk(S9, S9, S9, S9, 4'b0000));
        do_load(16'h9999, 4'b0000, 1'b0);
        wait_frame();

        // Reset at idx=2, cnt=5 with a load sitting in pending
        idle(10);
        do_load(16'h8888, 4'b1111, 1'b0);
        idle(10);
        rst_n = 1'b0;
        #1;
        check("reset_mid_frame", {19'b0, fd, an, dp_out, cc}, {19'b0, 1'b0, 4'b1111, 1'b1, SB});
        idle(3);
        exp_q.push_back(mk(SB, SB, SB, SB, 4'b0000));
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fd !== 1'b1 && n < 100);
        check("first_frame_done_latency", 32'(n), 32'd32);

        // Decimal point on digit 2 only
        frame_test(16'h5555, 4'b0100, 1'b0, mk(S5, S5, S5, S5, 4'b0100));

        idle(2);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
